// File: rtl/lapdfd_tap_scheduler.sv
// LaPDFD tap shadow/live bank scheduler: quiet-point swap plus rxValid flush.
// Optional readback port under LAPDFD_TAP_READBACK_EN.
module lapdfd_tap_scheduler #(
  parameter int NUM_TAPS     = 14,
  parameter int TAP_W        = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int FLUSH_CYCLES = 4,
  parameter int MAX_WAIT     = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_cfg_valid,
  output logic             io_cfg_ready,
  input  logic [3:0]       io_cfg_addr,
  input  logic [TAP_W-1:0] io_cfg_data,
  input  logic             io_commit_valid,
  output logic             io_commit_ready,
  input  logic             io_ffe_out_valid,
  input  logic             io_lapdfd_rxValid,
  output logic             io_rxValid,
  output logic [TAP_W-1:0] io_taps_0,
  output logic [TAP_W-1:0] io_taps_1,
  output logic [TAP_W-1:0] io_taps_2,
  output logic [TAP_W-1:0] io_taps_3,
  output logic [TAP_W-1:0] io_taps_4,
  output logic [TAP_W-1:0] io_taps_5,
  output logic [TAP_W-1:0] io_taps_6,
  output logic [TAP_W-1:0] io_taps_7,
  output logic [TAP_W-1:0] io_taps_8,
  output logic [TAP_W-1:0] io_taps_9,
  output logic [TAP_W-1:0] io_taps_10,
  output logic [TAP_W-1:0] io_taps_11,
  output logic [TAP_W-1:0] io_taps_12,
  output logic [TAP_W-1:0] io_taps_13,
`ifdef LAPDFD_TAP_READBACK_EN
  input  logic [3:0]       io_rd_addr,
  input  logic             io_rd_bank,
  output logic [TAP_W-1:0] io_rd_data,
`endif
  output logic             io_busy,
  output logic             io_commit_done,
  output logic             io_forced,
  output logic             io_cfg_err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [FW-1:0] FL_LAST   = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_SWAP,
    S_FLUSH
  } state_t;

  state_t           r_state;
  logic             r_idle;
  logic             r_busy;
  logic             r_done;
  logic             r_forced;
  logic             r_err;
  logic [GW-1:0]    r_gap;
  logic [WW-1:0]    r_wait;
  logic [FW-1:0]    r_flush;
  logic [TAP_W-1:0] r_shadow [NUM_TAPS];
  logic [TAP_W-1:0] r_live   [NUM_TAPS];

  logic w_wr;
  logic w_cm;
  logic w_addr_ok;
  logic w_gap_hit;
  logic w_blank;

  assign w_wr      = io_cfg_valid & r_idle;
  assign w_cm      = io_commit_valid & r_idle;
  assign w_addr_ok = (io_cfg_addr < 4'(NUM_TAPS));
  assign w_gap_hit = ~io_ffe_out_valid
                   & (r_gap == GAP_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idle   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_forced <= 1'b0;
      r_err    <= 1'b0;
      r_gap    <= '0;
      r_wait   <= '0;
      r_flush  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_wr) begin
            if (w_addr_ok)
              r_shadow[io_cfg_addr] <= io_cfg_data;
            else
              r_err <= 1'b1;
          end
          // a same-cycle commit picks up the write above
          if (w_cm) begin
            r_state  <= S_ARMED;
            r_idle   <= 1'b0;
            r_busy   <= 1'b1;
            r_forced <= 1'b0;
            r_err    <= 1'b0;
            r_gap    <= '0;
            r_wait   <= '0;
          end
        end
        S_ARMED: begin
          if (r_wait != WAIT_MAX)
            r_wait <= r_wait + 1'b1;
          if (io_ffe_out_valid)
            r_gap <= '0;
          else if (r_gap != GAP_MAX)
            r_gap <= r_gap + 1'b1;
          if (w_gap_hit) begin
            r_state <= S_SWAP;
          end else if (r_wait >= WAIT_LAST) begin
            r_state  <= S_SWAP;
            r_forced <= 1'b1;
          end
        end
        S_SWAP: begin
          for (int i = 0; i < NUM_TAPS; i++)
            r_live[i] <= r_shadow[i];
          r_state <= S_FLUSH;
          r_flush <= '0;
          r_done  <= (FLUSH_CYCLES == 1);
        end
        S_FLUSH: begin
          if (r_flush == FL_LAST) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_flush <= r_flush + 1'b1;
            r_done  <= ((r_flush + 1'b1) == FL_LAST);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign w_blank = (r_state == S_SWAP)
                 | (r_state == S_FLUSH);

  assign io_rxValid      = io_lapdfd_rxValid & ~w_blank;
  assign io_cfg_ready    = r_idle;
  assign io_commit_ready = r_idle;
  assign io_busy         = r_busy;
  assign io_commit_done  = r_done;
  assign io_forced       = r_forced;
  assign io_cfg_err      = r_err;

  assign io_taps_0  = r_live[0];
  assign io_taps_1  = r_live[1];
  assign io_taps_2  = r_live[2];
  assign io_taps_3  = r_live[3];
  assign io_taps_4  = r_live[4];
  assign io_taps_5  = r_live[5];
  assign io_taps_6  = r_live[6];
  assign io_taps_7  = r_live[7];
  assign io_taps_8  = r_live[8];
  assign io_taps_9  = r_live[9];
  assign io_taps_10 = r_live[10];
  assign io_taps_11 = r_live[11];
  assign io_taps_12 = r_live[12];
  assign io_taps_13 = r_live[13];

`ifdef LAPDFD_TAP_READBACK_EN
  logic w_rd_ok;
  assign w_rd_ok = (io_rd_addr < 4'(NUM_TAPS));

  always_comb begin
    io_rd_data = '0;
    if (w_rd_ok) begin
      if (io_rd_bank)
        io_rd_data = r_shadow[io_rd_addr];
      else
        io_rd_data = r_live[io_rd_addr];
    end
  end
`endif

endmodule
